// File: rtl/cv32e40p_obi_arb_pkg.sv
// Shared types and limits for the cv32e40p OBI instruction/data memory arbiter.
package cv32e40p_obi_arb_pkg;

  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} arb_src_e;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

  localparam int unsigned ARB_MAX_OUTSTANDING_LIMIT = 8;

endpackage

// File: rtl/cv32e40p_obi_arb_src_fifo.sv
// In-order FIFO of granted-transaction sources; push and pop may coincide even when full.
module cv32e40p_obi_arb_src_fifo
  import cv32e40p_obi_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  arb_src_e         data_i,
  input  logic             pop_i,
  output arb_src_e         head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  arb_src_e             mem_q [DEPTH];
  arb_src_e             mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push_eff, pop_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    pop_eff  = pop_i & ~empty_o;
    push_eff = push_i & (~full_o | pop_eff);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_eff) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_eff) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cv32e40p_obi_mem_arbiter.sv
// Two-to-one OBI arbiter (fetch + load/store onto one memory port) with in-order response routing.
// Define CV32E40P_ARB_RR_EN for round-robin ties; otherwise data has fixed priority.
module cv32e40p_obi_mem_arbiter
  import cv32e40p_obi_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   instr_req_i,
  input  logic [ADDR_W-1:0]                      instr_addr_i,
  output logic                                   instr_gnt_o,
  output logic                                   instr_rvalid_o,
  output logic [DATA_W-1:0]                      instr_rdata_o,
  input  logic                                   data_req_i,
  input  logic                                   data_we_i,
  input  logic [DATA_W/8-1:0]                    data_be_i,
  input  logic [ADDR_W-1:0]                      data_addr_i,
  input  logic [DATA_W-1:0]                      data_wdata_i,
  output logic                                   data_gnt_o,
  output logic                                   data_rvalid_o,
  output logic [DATA_W-1:0]                      data_rdata_o,
  output logic                                   mem_req_o,
  output logic                                   mem_we_o,
  output logic [DATA_W/8-1:0]                    mem_be_o,
  output logic [ADDR_W-1:0]                      mem_addr_o,
  output logic [DATA_W-1:0]                      mem_wdata_o,
  input  logic                                   mem_gnt_i,
  input  logic                                   mem_rvalid_i,
  input  logic [DATA_W-1:0]                      mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   resp_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DEPTH =
    (MAX_OUTSTANDING > ARB_MAX_OUTSTANDING_LIMIT) ? ARB_MAX_OUTSTANDING_LIMIT :
    (MAX_OUTSTANDING < 1) ? 1 : MAX_OUTSTANDING;

  arb_state_e       state_q, state_d;
  arb_src_e         lock_src_q, lock_src_d;
  arb_src_e         winner, sel, fifo_head;
  logic             resp_err_q, resp_err_d;
  logic             init_q;
  logic             blocked, any_req, push, pop, full_eff;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
`ifdef CV32E40P_ARB_RR_EN
  arb_src_e         last_q, last_d;
`endif

  // init_q holds the handshake/response outputs low for the first cycle after reset release.
  always_comb begin
    blocked  = rst_i | init_q;
    pop      = mem_rvalid_i & ~fifo_empty & ~blocked;
    full_eff = fifo_full & ~pop;

    winner = data_req_i ? SRC_DATA : SRC_INSTR;
`ifdef CV32E40P_ARB_RR_EN
    if (instr_req_i & data_req_i) begin
      winner = (last_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    end
`endif

    state_d    = state_q;
    lock_src_d = lock_src_q;
    if (state_q == ARB_LOCKED) begin
      sel     = lock_src_q;
      any_req = (lock_src_q == SRC_DATA) ? data_req_i : instr_req_i;
    end else begin
      sel     = winner;
      any_req = instr_req_i | data_req_i;
    end

    mem_req_o = any_req & ~full_eff & ~blocked;
    push      = mem_req_o & mem_gnt_i;

    case (state_q)
      ARB_IDLE: begin
        if (mem_req_o & ~mem_gnt_i) begin
          state_d    = ARB_LOCKED;
          lock_src_d = sel;
        end
      end
      ARB_LOCKED: begin
        if (push) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (sel == SRC_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_we_o    = 1'b0;
      mem_be_o    = '1;
      mem_addr_o  = instr_addr_i;
      mem_wdata_o = '0;
    end

    instr_gnt_o    = push & (sel == SRC_INSTR);
    data_gnt_o     = push & (sel == SRC_DATA);
    instr_rvalid_o = pop & (fifo_head == SRC_INSTR);
    data_rvalid_o  = pop & (fifo_head == SRC_DATA);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;

    resp_err_d = resp_err_q | (mem_rvalid_i & fifo_empty & ~blocked);
`ifdef CV32E40P_ARB_RR_EN
    last_d = push ? sel : last_q;
`endif
  end

  assign outstanding_o = fifo_count;
  assign resp_err_o    = resp_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      lock_src_q <= SRC_INSTR;
      resp_err_q <= 1'b0;
      init_q     <= 1'b1;
`ifdef CV32E40P_ARB_RR_EN
      last_q     <= SRC_INSTR;
`endif
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
      resp_err_q <= resp_err_d;
      init_q     <= 1'b0;
`ifdef CV32E40P_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  cv32e40p_obi_arb_src_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_src_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (sel),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_cv32e40p_obi_mem_arbiter.sv
// Self-checking bench for cv32e40p_obi_mem_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_cv32e40p_obi_mem_arbiter;

  localparam int unsigned MAXO = 2;
`ifdef CV32E40P_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  outstanding_o;
  logic        resp_err_o;

  cv32e40p_obi_mem_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .ADDR_W          (32),
    .DATA_W          (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .outstanding_o  (outstanding_o),
    .resp_err_o     (resp_err_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of outstanding sources (0 = fetch, 1 = load/store).
  bit q[$];
  bit m_err = 1'b0, m_locked = 1'b0, m_lsrc = 1'b0, m_last = 1'b0, m_jr = 1'b0;
  bit e_blk, e_pop, e_full, e_req, e_sel, e_ig, e_dg, e_ir, e_dr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    bit any;
    e_blk  = rst_i || m_jr;
    e_pop  = mem_rvalid_i && (q.size() > 0) && !e_blk;
    e_full = (q.size() == MAXO) && !e_pop;
    if (m_locked) begin
      e_sel = m_lsrc;
      any   = m_lsrc ? data_req_i : instr_req_i;
    end else begin
      any = instr_req_i || data_req_i;
      if (instr_req_i && data_req_i) e_sel = RR ? !m_last : 1'b1;
      else                           e_sel = data_req_i;
    end
    e_req = any && !e_full && !e_blk;
    e_ig  = e_req && mem_gnt_i && !e_sel;
    e_dg  = e_req && mem_gnt_i && e_sel;
    e_ir  = e_pop && (q[0] == 1'b0);
    e_dr  = e_pop && (q[0] == 1'b1);
  endtask

  task automatic check_all();
    chk("mem_req", mem_req_o, e_req);
    chk("instr_gnt", instr_gnt_o, e_ig);
    chk("data_gnt", data_gnt_o, e_dg);
    chk("instr_rvalid", instr_rvalid_o, e_ir);
    chk("data_rvalid", data_rvalid_o, e_dr);
    chk("instr_rdata", instr_rdata_o, mem_rdata_i);
    chk("data_rdata", data_rdata_o, mem_rdata_i);
    chk("outstanding", outstanding_o, q.size());
    chk("resp_err", resp_err_o, m_err);
    if (e_req) begin
      chk("mem_addr", mem_addr_o, e_sel ? data_addr_i : instr_addr_i);
      chk("mem_we", mem_we_o, e_sel ? data_we_i : 1'b0);
      chk("mem_be", mem_be_o, e_sel ? data_be_i : 4'hF);
      chk("mem_wdata", mem_wdata_o, e_sel ? data_wdata_i : 32'h0);
    end
  endtask

  task automatic model_commit();
    bit hs;
    if (rst_i) begin
      q.delete();
      m_err = 0; m_locked = 0; m_last = 0; m_jr = 1;
    end else begin
      if (mem_rvalid_i && (q.size() == 0) && !e_blk) m_err = 1;
      if (e_pop) void'(q.pop_front());
      hs = e_req && mem_gnt_i;
      if (hs) begin
        q.push_back(e_sel);
        m_last = e_sel;
      end
      if (m_locked) begin
        if (hs) m_locked = 0;
      end else if (e_req && !mem_gnt_i) begin
        m_locked = 1;
        m_lsrc   = e_sel;
      end
      m_jr = 0;
    end
  endtask

  task automatic eval_chk();
    #1;
    model_eval();
    check_all();
  endtask

  task automatic commit_tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    eval_chk();
    commit_tick();
  endtask

  task automatic idle_in();
    instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask

  initial begin
    bit ig, dg;
    rst_i = 1; idle_in();
    instr_addr_i = 0; data_addr_i = 0; data_we_i = 0; data_be_i = 0;
    data_wdata_i = 0; mem_rdata_i = 0;
    @(posedge clk); #1;
    m_jr = 1;

    // Reset: everything forced low while reset and for the following cycle.
    instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    eval_chk();
    chk("rst_mem_req", mem_req_o, 1'b0);
    commit_tick();
    rst_i = 0;
    eval_chk();
    chk("post_rst_gnt", data_gnt_o | instr_gnt_o, 1'b0);
    commit_tick();
    idle_in();
    cyc();

    // Lone fetch.
    instr_req_i = 1; instr_addr_i = 32'h8000_0000; mem_gnt_i = 1;
    eval_chk();
    chk("fetch_gnt", instr_gnt_o, 1'b1);
    commit_tick();
    idle_in(); mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
    eval_chk();
    chk("fetch_rvalid", instr_rvalid_o, 1'b1);
    chk("fetch_no_drvalid", data_rvalid_o, 1'b0);
    chk("fetch_rdata", instr_rdata_o, 32'h13);
    commit_tick();

    // Conflict held under lock for 3 cycles.
    idle_in();
    instr_req_i = 1; instr_addr_i = 32'h0000_1000;
    data_req_i = 1; data_addr_i = 32'h0000_2000; data_we_i = 1; data_be_i = 4'h3;
    data_wdata_i = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = (i == 3);
      eval_chk();
      chk("lock_addr", mem_addr_o, 32'h0000_2000);
      commit_tick();
    end
    data_addr_i = 32'h0000_2004; mem_gnt_i = 1;
    eval_chk();
    chk("tie_after_lock", mem_addr_o, RR ? 32'h0000_1000 : 32'h0000_2004);
    commit_tick();
    idle_in(); mem_rvalid_i = 1; mem_rdata_i = 32'h1;
    cyc(); cyc();
    mem_rvalid_i = 0; cyc();

    // Full stall, then concurrent pop re-enables the request.
    instr_req_i = 1; mem_gnt_i = 1;
    instr_addr_i = 32'h100; cyc();
    instr_addr_i = 32'h104; cyc();
    instr_addr_i = 32'h108;
    eval_chk();
    chk("full_outstanding", outstanding_o, 2'd2);
    chk("full_no_req", mem_req_o, 1'b0);
    commit_tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    eval_chk();
    chk("pop_reenables_req", mem_req_o, 1'b1);
    commit_tick();
    idle_in(); mem_rvalid_i = 1;
    cyc(); cyc();
    idle_in(); cyc();

    // Ordering: fetch then load, responses return in order.
    instr_req_i = 1; instr_addr_i = 32'h200; mem_gnt_i = 1; cyc();
    idle_in(); data_req_i = 1; data_we_i = 0; data_addr_i = 32'h300; mem_gnt_i = 1; cyc();
    idle_in(); mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA_AAAA;
    eval_chk();
    chk("order_first", {instr_rvalid_o, data_rvalid_o, instr_rdata_o}, {2'b10, 32'hAAAA_AAAA});
    commit_tick();
    mem_rdata_i = 32'hDEAD_BEEF;
    eval_chk();
    chk("order_second", {instr_rvalid_o, data_rvalid_o, data_rdata_o}, {2'b01, 32'hDEAD_BEEF});
    commit_tick();

    // Spurious response on an empty FIFO.
    mem_rvalid_i = 1;
    eval_chk();
    chk("spur_no_fwd", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    commit_tick();
    idle_in(); cyc();
    eval_chk();
    chk("spur_err_sticky", resp_err_o, 1'b1);
    chk("spur_outstanding", outstanding_o, 2'd0);
    commit_tick();
    rst_i = 1; cyc();
    rst_i = 0; cyc();
    eval_chk();
    chk("err_cleared", resp_err_o, 1'b0);
    commit_tick();

    // Reset while locked with one outstanding.
    instr_req_i = 1; instr_addr_i = 32'h400; mem_gnt_i = 1; cyc();
    idle_in(); data_req_i = 1; data_addr_i = 32'h500; cyc();
    cyc();
    rst_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    eval_chk();
    chk("rst_lock_out", {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}, 4'b0);
    commit_tick();
    rst_i = 0; idle_in(); cyc();
    instr_req_i = 1; instr_addr_i = 32'h600;
    eval_chk();
    chk("rst_unlocked", mem_addr_o, 32'h600);
    chk("rst_outstanding", outstanding_o, 2'd0);
    commit_tick();
    idle_in(); mem_rvalid_i = 1; cyc();
    idle_in(); cyc();

    // Randomized traffic, requesters obey the OBI hold rule.
    for (int n = 0; n < 600; n++) begin
      eval_chk();
      ig = e_ig; dg = e_dg;
      commit_tick();
      rst_i = ($urandom_range(0, 99) == 0);
      if (!instr_req_i || ig || rst_i) begin
        instr_req_i  = $urandom_range(0, 1);
        instr_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req_i || dg || rst_i) begin
        data_req_i   = $urandom_range(0, 1);
        data_addr_i  = $urandom;
        data_we_i    = $urandom_range(0, 1);
        data_be_i    = 4'($urandom);
        data_wdata_i = $urandom;
      end
      mem_gnt_i    = $urandom_range(0, 1);
      mem_rvalid_i = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
      mem_rdata_i  = $urandom;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
